pong_compositor: RTL
====================

Name: pong_compositor

Overview:
- Parametrised successor of the Pong pixel renderer.
- Composites N generic rectangles with per-rectangle colour and enable, the centre net, the scoreboard layer and the text overlay, in priority order, into multi-bit RGB.
- Adds display modes and frame-counted text blinking.
- Sits between the VGA timing generator and the DAC pins. Pixel-coordinate inputs are resolved to RGB with a fixed 2-cycle latency.

Parameters:
- NUM_RECTS, 4, number of rectangle sprites (1..8)
- COLOR_BITS, 4, bits per colour channel
- H_VIDEO, 640, active pixels per line
- V_VIDEO, 480, active lines per frame
- NET_WIDTH, 12, net column width in pixels, centred on H_VIDEO/2
- NET_PERIOD, 24, net vertical period in lines
- NET_ON, 12, lines per period the net is drawn
- NET_PHASE, 18, net phase value loaded on line 0
- BLINK_LOG2, 5, frame-counter bit that gates text blink (period 2^(BLINK_LOG2+1) frames)

Ports:
- clk_0  in  1  pixel clock, 25.175 MHz
- rst  in  1  asynchronous, active-high reset
- pixel_x  in  10  current pixel column
- pixel_y  in  10  current pixel line
- video_on  in  1  active video region flag
- rect_x  in  10*NUM_RECTS  packed left edges; rect i at bits [10i+9:10i]
- rect_y  in  10*NUM_RECTS  packed top edges
- rect_w  in  10*NUM_RECTS  packed widths
- rect_h  in  10*NUM_RECTS  packed heights
- rect_en  in  NUM_RECTS  per-rectangle visible flag
- rect_color  in  3*COLOR_BITS*NUM_RECTS  packed {r,g,b} per rectangle
- fg_color  in  3*COLOR_BITS  {r,g,b} for net, score and text
- bg_color  in  3*COLOR_BITS  {r,g,b} background
- score_on  in  1  scoreboard pixel hit, same-cycle with pixel_x/y
- text_on  in  1  overlay text pixel hit, same-cycle with pixel_x/y
- mode  in  2  0=playfield, 1=startup, 2=game over, 3=blank
- blink_en  in  1  enables text blinking in startup mode
- red  out  COLOR_BITS  red channel
- green  out  COLOR_BITS  green channel
- blue  out  COLOR_BITS  blue channel
- frame_tick  out  1  one-cycle pulse on last active pixel of a frame

Behaviour:
- Reset (async, rst=1): red, green, blue = 0; frame_tick = 0; all pipeline registers = 0; net line counter = 0; frame counter = 0. Outputs stay 0 until two clocks after rst deasserts.
- Stage 1 (registered) captures:
  - rect hit vector: hit_i = rect_en[i] && x>=rect_x && x<rect_x+rect_w && y>=rect_y && y<rect_y+rect_h. Sums are computed in 11 bits, so there is no wrap. w=0 or h=0 never hits.
  - net hit, score_on, text_on, mode, video_on.
- Stage 2 (registered) resolves priority:
  - mode 3, or stage-1 video_on=0: RGB = 0.
  - mode 1: text_on && (!blink_en || frame_cnt[BLINK_LOG2]==0) gives fg_color, else bg_color.
  - mode 2: text_on gives fg_color, else bg_color. No blink.
  - mode 0, highest priority first: lowest-index hit rect (its colour), then score_on (fg), then net (fg), then bg_color.
- Latency: pixel presented at cycle N appears on red/green/blue at N+2. Mode, colour and enable changes take effect with the same 2-cycle latency.
- Net line counter:
  - Updates only when video_on=1 and pixel_x==0.
  - If pixel_y==0, loads NET_PHASE. Otherwise increments; NET_PERIOD-1 wraps to 0.
  - Net hit uses the counter value for the current line, i.e. the next-state value at pixel_x==0 and the register value thereafter.
  - net = (H_VIDEO/2-NET_WIDTH/2 <= x <= H_VIDEO/2+NET_WIDTH/2-1) && line_phase < NET_ON.
- Frame counter:
  - BLINK_LOG2+1 bits. Increments, wrapping, when video_on && pixel_x==H_VIDEO-1 && pixel_y==V_VIDEO-1.
  - frame_tick is registered high for exactly that one cycle, 1 cycle after the condition.
- Blink bit is sampled in stage 1 with the pixel, so a frame never shows mixed blink state mid-pixel.
- Reset mid-frame: net counter clears; it resynchronises at the next line-0.

Test Plan:
- Reset: hold rst=1 for 5 clocks with video_on=1 and rect 0 covering the screen -> RGB=0 and frame_tick=0 throughout. Deassert -> rect colour appears on the 2nd clock.
- Latency/priority: rect0 at (100,100,16,16) colour 0xF00, rect1 at (108,108,16,16) colour 0x0F0, fg=0xFFF. Pixel (110,110) -> 0xF00; pixel (120,120) -> 0x0F0; pixel (50,50) -> bg. Each result appears 2 clocks after its pixel.
- Net pattern at defaults: line 0 phase 18 -> x=314..325 shows bg. Lines 6..17 show fg at x=314 and x=325. x=313 and x=326 always show bg. Line 30 (phase 0) shows fg again.
- Boundaries: rect at x=630, w=16 -> x=639 hit, no wrap to x=0..5. rect_w=0 -> never hit. rect_en=0 -> never hit.
- Blink: mode 1, blink_en=1, text_on=1, BLINK_LOG2=1 -> text fg for 2 frames, bg for 2 frames, repeating. frame_tick pulses once per frame. blink_en=0 -> always fg.
- Modes: mode 3 -> RGB 0 regardless of hits. mode 2 with text_on=0 -> bg_color. video_on=0 in mode 0 -> 0.

Source files
------------

// File: rtl/pong_compositor.sv
// pong_compositor: two-stage pixel compositor layering rectangles, net, score and text into RGB.
module pong_compositor #(
   parameter int NUM_RECTS  = 4,
   parameter int COLOR_BITS = 4,
   parameter int H_VIDEO    = 640,
   parameter int V_VIDEO    = 480,
   parameter int NET_WIDTH  = 12,
   parameter int NET_PERIOD = 24,
   parameter int NET_ON     = 12,
   parameter int NET_PHASE  = 18,
   parameter int BLINK_LOG2 = 5
) (
   input  logic                              clk_0,
   input  logic                              rst,
   input  logic [9:0]                        pixel_x,
   input  logic [9:0]                        pixel_y,
   input  logic                              video_on,
   input  logic [10*NUM_RECTS-1:0]           rect_x,
   input  logic [10*NUM_RECTS-1:0]           rect_y,
   input  logic [10*NUM_RECTS-1:0]           rect_w,
   input  logic [10*NUM_RECTS-1:0]           rect_h,
   input  logic [NUM_RECTS-1:0]              rect_en,
   input  logic [3*COLOR_BITS*NUM_RECTS-1:0] rect_color,
   input  logic [3*COLOR_BITS-1:0]           fg_color,
   input  logic [3*COLOR_BITS-1:0]           bg_color,
   input  logic                              score_on,
   input  logic                              text_on,
   input  logic [1:0]                        mode,
   input  logic                              blink_en,
   output logic [COLOR_BITS-1:0]             red,
   output logic [COLOR_BITS-1:0]             green,
   output logic [COLOR_BITS-1:0]             blue,
   output logic                              frame_tick
);
   localparam int CW = 3*COLOR_BITS;
   localparam int PW = $clog2(NET_PERIOD+1);
   localparam logic [9:0]    NET_L   = 10'(H_VIDEO/2 - NET_WIDTH/2);
   localparam logic [9:0]    NET_R   = 10'(H_VIDEO/2 + NET_WIDTH/2 - 1);
   localparam logic [9:0]    X_LAST  = 10'(H_VIDEO-1);
   localparam logic [9:0]    Y_LAST  = 10'(V_VIDEO-1);
   localparam logic [PW-1:0] PH_LOAD = PW'(NET_PHASE);
   localparam logic [PW-1:0] PH_MAX  = PW'(NET_PERIOD-1);
   localparam logic [PW:0]   PH_ON   = (PW+1)'(NET_ON);

   logic [NUM_RECTS-1:0]    w_hit;
   logic                    w_upd, w_net, w_last;
   logic [PW-1:0]           r_phase, w_phase_nxt, w_phase;
   logic [BLINK_LOG2:0]     r_frame_cnt;
   logic [NUM_RECTS-1:0]    r1_hit;
   logic                    r1_net, r1_score, r1_text, r1_vid, r1_blinked;
   logic [1:0]              r1_mode;
   logic [CW*NUM_RECTS-1:0] r1_rect_col;
   logic [CW-1:0]           r1_fg, r1_bg;
   logic [CW-1:0]           w_sel, w_play, w_rgb, r_rgb;
   logic                    w_any, w_txt;

   // Sums are widened to 11 bits so a rectangle near the right/bottom edge never wraps to 0.
   for (genvar g = 0; g < NUM_RECTS; g++) begin : g_hit
      assign w_hit[g] = rect_en[g]
         && pixel_x >= rect_x[10*g +: 10]
         && {1'b0, pixel_x} < {1'b0, rect_x[10*g +: 10]} + {1'b0, rect_w[10*g +: 10]}
         && pixel_y >= rect_y[10*g +: 10]
         && {1'b0, pixel_y} < {1'b0, rect_y[10*g +: 10]} + {1'b0, rect_h[10*g +: 10]};
   end

   // The line phase is advanced at column 0; that column already uses the new value.
   assign w_upd       = video_on && pixel_x == '0;
   assign w_phase_nxt = (pixel_y == '0) ? PH_LOAD : (r_phase == PH_MAX) ? '0 : r_phase + 1'b1;
   assign w_phase     = w_upd ? w_phase_nxt : r_phase;
   assign w_net       = pixel_x >= NET_L && pixel_x <= NET_R && {1'b0, w_phase} < PH_ON;
   assign w_last      = video_on && pixel_x == X_LAST && pixel_y == Y_LAST;

   always_ff @(posedge clk_0 or posedge rst) begin
      if (rst) begin
         r_phase     <= '0;
         r_frame_cnt <= '0;
         frame_tick  <= 1'b0;
         r1_hit      <= '0;
         r1_net      <= 1'b0;
         r1_score    <= 1'b0;
         r1_text     <= 1'b0;
         r1_vid      <= 1'b0;
         r1_blinked  <= 1'b0;
         r1_mode     <= '0;
         r1_rect_col <= '0;
         r1_fg       <= '0;
         r1_bg       <= '0;
         r_rgb       <= '0;
      end else begin
         if (w_upd) r_phase <= w_phase_nxt;
         if (w_last) r_frame_cnt <= r_frame_cnt + 1'b1;
         frame_tick  <= w_last;
         r1_hit      <= w_hit;
         r1_net      <= w_net;
         r1_score    <= score_on;
         r1_text     <= text_on;
         r1_vid      <= video_on;
         r1_blinked  <= blink_en && r_frame_cnt[BLINK_LOG2];
         r1_mode     <= mode;
         r1_rect_col <= rect_color;
         r1_fg       <= fg_color;
         r1_bg       <= bg_color;
         r_rgb       <= w_rgb;
      end
   end

   // Scan from the top index down so the lowest-index hit wins.
   always_comb begin
      w_sel = '0;
      w_any = 1'b0;
      for (int i = NUM_RECTS-1; i >= 0; i--) begin
         if (r1_hit[i]) begin
            w_any = 1'b1;
            w_sel = r1_rect_col[CW*i +: CW];
         end
      end
      w_play = w_any ? w_sel : (r1_score || r1_net) ? r1_fg : r1_bg;
      w_txt  = r1_text && !(r1_mode == 2'd1 && r1_blinked);
      w_rgb  = (!r1_vid || r1_mode == 2'd3) ? '0 : (r1_mode == 2'd0) ? w_play : w_txt ? r1_fg : r1_bg;
   end

   assign red   = r_rgb[3*COLOR_BITS-1:2*COLOR_BITS];
   assign green = r_rgb[2*COLOR_BITS-1:COLOR_BITS];
   assign blue  = r_rgb[COLOR_BITS-1:0];
endmodule
